// File: rtl/hdr_tone_map.sv
// HDR tone mapper: per-frame peak tracking, serial reciprocal-gain divider, 2-stage scale/saturate path.
// Optional HDR_TM_STATS_EN exposes frame_max_o and gain_o for debug/statistics.
module hdr_tone_map #(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int GAIN_WIDTH = 20,
    parameter int GAIN_FRAC  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   data_i,
    input  logic                  valid_i,
    input  logic                  sof_i,
    output logic [OUT_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    output logic                  sof_o,
    output logic                  busy_o
`ifdef HDR_TM_STATS_EN
    ,
    output logic [IN_WIDTH-1:0]   frame_max_o,
    output logic [GAIN_WIDTH-1:0] gain_o
`endif
);

    localparam int PROD_W = IN_WIDTH + GAIN_WIDTH;
    localparam int CNT_W  = $clog2(GAIN_WIDTH);

    localparam logic [GAIN_WIDTH-1:0] NUMER      = GAIN_WIDTH'(((2 ** OUT_WIDTH) - 1) * (2 ** GAIN_FRAC));
    localparam logic [GAIN_WIDTH-1:0] GAIN_RESET = GAIN_WIDTH'((2 ** GAIN_FRAC) >> (IN_WIDTH - OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]  OUT_MAX    = {OUT_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(GAIN_WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DIV  = 1'b1;

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IN_WIDTH-1:0]   r_rem;
    logic [GAIN_WIDTH-1:0] r_quo;
    logic [IN_WIDTH-1:0]   r_den;
    logic [IN_WIDTH-1:0]   r_frame_max;
    logic [GAIN_WIDTH-1:0] r_gain_pending;
    logic [GAIN_WIDTH-1:0] r_gain_active;
    logic                  r_pending_valid;

    logic [PROD_W-1:0]     r_prod;
    logic                  r_valid_s1;
    logic                  r_sof_s1;
    logic [OUT_WIDTH-1:0]  r_data_o;
    logic                  r_valid_o;
    logic                  r_sof_o;

    logic                  w_sof;
    logic                  w_load_gain;
    logic [GAIN_WIDTH-1:0] w_gain_use;
    logic [IN_WIDTH-1:0]   w_new_den;
    logic [IN_WIDTH:0]     w_trial;
    logic                  w_q_bit;
    logic [IN_WIDTH-1:0]   w_rem_next;
    logic [GAIN_WIDTH-1:0] w_quo_next;
    logic                  w_div_last;
    logic [PROD_W-1:0]     w_scaled;
    logic                  w_sat;

    assign w_sof       = valid_i & sof_i;
    assign w_load_gain = w_sof & r_pending_valid;
    // The sof pixel itself must already see the newly promoted gain.
    assign w_gain_use  = w_load_gain ? r_gain_pending : r_gain_active;
    assign w_new_den   = (r_frame_max == '0) ? IN_WIDTH'(1) : r_frame_max;

    // NOTE: remainder stays below the divisor, so only the trial value needs the extra bit.
    assign w_trial    = {r_rem, r_quo[GAIN_WIDTH-1]};
    assign w_q_bit    = (w_trial >= {1'b0, r_den});
    assign w_rem_next = w_q_bit ? (w_trial[IN_WIDTH-1:0] - r_den) : w_trial[IN_WIDTH-1:0];
    assign w_quo_next = {r_quo[GAIN_WIDTH-2:0], w_q_bit};
    assign w_div_last = (r_state == ST_DIV) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_rem           <= '0;
            r_quo           <= '0;
            r_den           <= '0;
            r_frame_max     <= '0;
            r_gain_pending  <= GAIN_RESET;
            r_gain_active   <= GAIN_RESET;
            r_pending_valid <= 1'b0;
        end else begin
            if (valid_i) begin
                if (sof_i || (data_i > r_frame_max)) begin
                    r_frame_max <= data_i;
                end
            end

            // A new frame always restarts the divider, discarding any division in flight.
            if (w_sof) begin
                r_state <= ST_DIV;
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= NUMER;
                r_den   <= w_new_den;
            end else if (r_state == ST_DIV) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_div_last) begin
                    r_state         <= ST_IDLE;
                    r_gain_pending  <= w_quo_next;
                    r_pending_valid <= 1'b1;
                end
            end

            if (w_load_gain) begin
                r_gain_active   <= r_gain_pending;
                r_pending_valid <= 1'b0;
            end
        end
    end

    assign w_scaled = r_prod >> GAIN_FRAC;
    assign w_sat    = |w_scaled[PROD_W-1:OUT_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod     <= '0;
            r_valid_s1 <= 1'b0;
            r_sof_s1   <= 1'b0;
            r_data_o   <= '0;
            r_valid_o  <= 1'b0;
            r_sof_o    <= 1'b0;
        end else begin
            r_prod     <= PROD_W'(data_i) * PROD_W'(w_gain_use);
            r_valid_s1 <= valid_i;
            r_sof_s1   <= sof_i;
            r_data_o   <= w_sat ? OUT_MAX : w_scaled[OUT_WIDTH-1:0];
            r_valid_o  <= r_valid_s1;
            r_sof_o    <= r_sof_s1;
        end
    end

    assign data_o  = r_data_o;
    assign valid_o = r_valid_o;
    assign sof_o   = r_sof_o;
    assign busy_o  = (r_state == ST_DIV);

`ifdef HDR_TM_STATS_EN
    logic [IN_WIDTH-1:0] r_last_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_max <= '0;
        end else if (w_sof) begin
            r_last_max <= r_frame_max;
        end
    end

    assign frame_max_o = r_last_max;
    assign gain_o      = r_gain_active;
`endif

endmodule

// File: tb/tb_hdr_tone_map.sv
// Scoreboard bench for hdr_tone_map: directed frames with hand-computed pixel results.
module tb_hdr_tone_map;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data_i;
    logic        valid_i;
    logic        sof_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        sof_o;
    logic        busy_o;
`ifdef HDR_TM_STATS_EN
    logic [11:0] frame_max_o;
    logic [19:0] gain_o;
`endif

    hdr_tone_map dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .sof_i   (sof_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sof_o   (sof_o),
        .busy_o  (busy_o)
`ifdef HDR_TM_STATS_EN
        ,
        .frame_max_o (frame_max_o),
        .gain_o      (gain_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        int         cyc;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   busy_seen  = 0;
    int   next_id    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [11:0] d, input logic [7:0] e);
        @(negedge clk);
        if (busy_o === 1'b1) busy_seen++;
        valid_i = v;
        sof_i   = s;
        data_i  = d;
        if (v) begin
            sb.push_back('{data: e, sof: s, cyc: cyc + 2, id: next_id});
            next_id++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 12'd0, 8'd0);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_o", 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("data_o[px%0d]", e.id), data_o, e.data);
                check($sformatf("sof_o[px%0d]", e.id), sof_o, e.sof);
                check($sformatf("latency[px%0d]", e.id), cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst     = 1'b1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_data_o", data_o, 0);
        check("rst_valid_o", valid_o, 0);
        check("rst_sof_o", sof_o, 0);
        check("rst_busy_o", busy_o, 0);
        rst = 1'b0;

        // Reset gain 256: 4095 -> 255, 16 -> 1.
        drive(1, 0, 12'd4095, 8'd255);
        drive(1, 0, 12'd16, 8'd1);
        idle(3);

        // F0: still gain 256; hands off max 4095 (gain 255 pending).
        drive(1, 1, 12'd1000, 8'd62);
        busy_seen = 0;
        drive(1, 0, 12'd500, 8'd31);
        idle(29);
        check("busy_cycles", busy_seen, 20);

        // F1: all-zero frame; promotes 255, hands off 1000.
        drive(1, 1, 12'd0, 8'd0);
        repeat (29) drive(1, 0, 12'd0, 8'd0);

        // F2: gain 1044; hands off 0 (gain 1044480 pending).
        drive(1, 1, 12'd1000, 8'd254);
        drive(1, 0, 12'd500, 8'd127);
        drive(1, 0, 12'd2000, 8'd255);
        idle(27);

        // F3: gain 1044480 from the all-zero frame.
        drive(1, 1, 12'd1, 8'd255);
        drive(1, 0, 12'd4095, 8'd255);
        drive(1, 0, 12'd0, 8'd0);
        idle(5);
        drain();

        // Short frames keep aborting the divider, so gain stays 256.
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b0;
        sof_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 6; f++) begin
            drive(1, 1, 12'd4095, 8'd255);
            drive(1, 0, 12'd16, 8'd1);
            idle(8);
            check($sformatf("busy_stress[f%0d]", f), busy_o, 1);
        end
        idle(30);
        // Division of the last short frame (max 4095) finally completes: gain 255.
        drive(1, 1, 12'd4095, 8'd254);
        idle(3);
        drain();

        // Reset in the middle of a division discards it.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 12'd0, 8'd0);
        idle(5);
        check("busy_before_rst", busy_o, 1);
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b0;
        sof_i = 1'b0;
        @(negedge clk);
        check("midrst_busy_o", busy_o, 0);
        check("midrst_valid_o", valid_o, 0);
        check("midrst_data_o", data_o, 0);
        rst = 1'b0;
        idle(30);
        check("busy_after_abandon", busy_o, 0);
        drive(1, 1, 12'd16, 8'd1);
        drive(1, 0, 12'd4095, 8'd255);
        idle(3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdr_tone_map.md
HDR_TONE_MAP -- requirements
Module: hdr_tone_map

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 12: width of the merged HDR pixel input.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: width of the display pixel output.
REQ-003 SHALL have parameter GAIN_WIDTH, default 20: width of the gain (reciprocal) registers.
REQ-004 SHALL have parameter GAIN_FRAC, default 12: number of fractional bits in gain.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port data_i, input, IN_WIDTH: HDR pixel.
REQ-008 SHALL have port valid_i, input, 1: data_i qualifier.
REQ-009 SHALL have port sof_i, input, 1: start of frame; only meaningful with valid_i=1, marks the first pixel of a frame.
REQ-010 SHALL have port data_o, output, OUT_WIDTH: tone-mapped pixel.
REQ-011 SHALL have port valid_o, output, 1: data_o qualifier.
REQ-012 SHALL have port sof_o, output, 1: sof_i delayed with its pixel.
REQ-013 SHALL have port busy_o, output, 1: high while the gain divider iterates.

Function
REQ-014 SHALL track frame_max: the maximum data_i over valid pixels from one sof_i (inclusive) to the next sof_i (exclusive).
REQ-015 On a valid sof_i pixel, SHALL hand the running max to the divider and reload the tracker with that pixel's value.
REQ-016 Divider SHALL be an FSM with states IDLE and DIV: IDLE->DIV on the handoff; DIV->IDLE after exactly GAIN_WIDTH cycles; busy_o=1 only in DIV.
REQ-017 Divider SHALL compute gain = floor(((2^OUT_WIDTH-1)<<GAIN_FRAC) / max(frame_max,1)) by restoring division, one quotient bit per cycle; a max of 0 SHALL be treated as 1.
REQ-018 On DIV completion, SHALL load gain_pending and set pending_valid.
REQ-019 On a valid sof_i with pending_valid=1, SHALL copy gain_pending to gain_active (used from that sof pixel on) and clear pending_valid; gain_active SHALL change only at sof_i.
REQ-020 Consequence: frame N statistics SHALL apply to frame N+2.
REQ-021 If sof_i arrives while in DIV, SHALL abort the current division, restart with the new max, and leave gain_pending and gain_active unchanged.
REQ-022 Pixel path: stage 1 registers data_i*gain_active (IN_WIDTH+GAIN_WIDTH bits); stage 2 registers product>>GAIN_FRAC, saturated to 2^OUT_WIDTH-1.
REQ-023 Latency data_i->data_o SHALL be exactly 2 cycles; valid_o and sof_o SHALL be valid_i and sof_i delayed by 2 cycles.
REQ-024 The pixel path SHALL accept one pixel per cycle with no backpressure; invalid cycles SHALL not update frame_max.

Reset
REQ-025 On rst: data_o=0, valid_o=0, sof_o=0, busy_o=0, FSM=IDLE, pending_valid=0, frame_max=0.
REQ-026 On rst: gain_active=gain_pending=2^GAIN_FRAC>>(IN_WIDTH-OUT_WIDTH) (256 at defaults; a plain right shift by 4).
REQ-027 rst mid-division SHALL abandon the division with no gain update; rst SHALL take precedence over all concurrent events.

Configuration
REQ-028 Macro HDR_TM_STATS_EN defined: SHALL add output ports frame_max_o (IN_WIDTH, last handed-off frame max, reset 0) and gain_o (GAIN_WIDTH, gain_active).
REQ-029 Macro HDR_TM_STATS_EN undefined: SHALL omit those ports; function SHALL be otherwise identical.

Verification
REQ-030 After rst, valid data_i=4095 then 16 -> data_o=255 and 1, each 2 cycles later, with valid_o high.
REQ-031 Frame 0 max 1000, long frames -> gain 1044 from frame 2; pixel 1000 -> 254; pixel 500 -> 127.
REQ-032 Same gain 1044, pixel 2000 -> data_o=255 (saturated).
REQ-033 All-zero frame -> gain 1044480 two frames later; pixel 1 -> 255.
REQ-034 sof_i every 10 cycles -> busy_o never completes, gain stays 256; pixel 4095 -> 255.
REQ-035 rst asserted 5 cycles into DIV -> busy_o=0 next cycle, gain 256, valid_o=0.
